// File: rtl/mem_responder_pkg.sv
// Shared address map and decode helper for the memory responder.
package mem_responder_pkg;

    localparam logic [1:0]  IoRegion   = 2'b11;
    localparam logic [17:0] IoDataAddr = 18'h30000;
    localparam logic [17:0] IoStatAddr = 18'h30004;

    typedef enum logic [1:0] {
        SelRam,
        SelIoData,
        SelIoStat,
        SelIoOther
    } sel_e;

    function automatic sel_e decode_addr(input logic [17:0] addr);
        if (addr[17:16] != IoRegion) begin
            return SelRam;
        end else if (addr == IoDataAddr) begin
            return SelIoData;
        end else if (addr == IoStatAddr) begin
            return SelIoStat;
        end
        return SelIoOther;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Power-of-two byte FIFO; a push into a full FIFO succeeds when a pop happens in the same cycle.
module byte_fifo #(
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               wdata,
    input  logic                     pop,
    output logic [7:0]               rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [7:0]      mem_q [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0] count_q;
    logic            push_ok, pop_ok;

    assign full    = (count_q == CntW'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/mem_responder.sv
// Byte-wide memory responder: RAM plus a UART-style I/O window with TX/RX FIFOs.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned RAM_ADDR_BITS = 17,
    parameter int unsigned FIFO_DEPTH    = 8,
    parameter int unsigned FULL_SLACK    = 2
) (
    input  logic        clk,
    input  logic        rst_in,
    input  logic        mem_rw,
    input  logic [31:0] mem_a,
    input  logic [7:0]  mem_wdata,
    output logic [7:0]  mem_rdata,
    output logic        io_buffer_full,
    output logic        tx_valid,
    output logic [7:0]  tx_byte,
    input  logic        tx_ready,
    input  logic        rx_valid,
    input  logic [7:0]  rx_byte,
    output logic        sim_halt,
    output logic [1:0]  err_flags
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

    logic [7:0] ram [2**RAM_ADDR_BITS];

    sel_e            sel;
    logic            ram_we;
    logic            tx_push, tx_push_ok, tx_pop, tx_full, tx_empty;
    logic            rx_pop, rx_full, rx_empty;
    logic [7:0]      rx_head;
    logic [CntW-1:0] tx_count, tx_count_next, unused_rx_count;
    logic            unused_addr;
    logic [7:0]      rdata_d, rdata_q;
    logic            io_full_q, halt_q;
    logic [1:0]      err_q;

    assign unused_addr = ^mem_a[31:18];
    assign sel         = decode_addr(mem_a[17:0]);

    // A write presented while reset is held is a discarded transaction.
    assign ram_we  = mem_rw && (sel == SelRam) && !rst_in;
    assign tx_push = mem_rw && (sel == SelIoData);
    assign tx_pop  = tx_valid && tx_ready;
    assign rx_pop  = !mem_rw && (sel == SelIoData) && !rx_empty;

    assign tx_push_ok    = tx_push && (!tx_full || tx_pop);
    assign tx_count_next = tx_count + CntW'(tx_push_ok) - CntW'(tx_pop);

    assign tx_valid       = !tx_empty;
    assign mem_rdata      = rdata_q;
    assign io_buffer_full = io_full_q;
    assign sim_halt       = halt_q;
    assign err_flags      = err_q;

    always_comb begin
        rdata_d = 8'h00;
        if (!mem_rw) begin
            unique case (sel)
                SelRam:     rdata_d = ram[mem_a[RAM_ADDR_BITS-1:0]];
                SelIoData:  rdata_d = rx_empty ? 8'h00 : rx_head;
                SelIoStat:  rdata_d = {6'b0, !rx_empty, tx_full};
                SelIoOther: rdata_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[mem_a[RAM_ADDR_BITS-1:0]] <= mem_wdata;
    end

    always_ff @(posedge clk or posedge rst_in) begin
        if (rst_in) begin
            rdata_q   <= 8'h00;
            io_full_q <= 1'b0;
            halt_q    <= 1'b0;
            err_q     <= 2'b00;
        end else begin
            rdata_q   <= rdata_d;
            io_full_q <= (tx_count_next >= CntW'(FIFO_DEPTH - FULL_SLACK));
            if (mem_rw && (sel == SelIoStat)) halt_q <= 1'b1;
            if (rx_valid && rx_full && !rx_pop) err_q[1] <= 1'b1;
            if (tx_push && !tx_push_ok)         err_q[0] <= 1'b1;
        end
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst_in),
        .push  (tx_push_ok),
        .wdata (mem_wdata),
        .pop   (tx_pop),
        .rdata (tx_byte),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst_in),
        .push  (rx_valid),
        .wdata (rx_byte),
        .pop   (rx_pop),
        .rdata (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (unused_rx_count)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: read data and TX bytes checked against queued expectations.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        rst_in;
    logic        mem_rw;
    logic [31:0] mem_a;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        io_buffer_full;
    logic        tx_valid;
    logic [7:0]  tx_byte;
    logic        tx_ready;
    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        sim_halt;
    logic [1:0]  err_flags;

    typedef struct {
        int         due;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] tx_q[$];
    int         cyc = 0;
    int         n_pass = 0;
    int         n_total = 0;

    mem_responder dut (
        .clk            (clk),
        .rst_in         (rst_in),
        .mem_rw         (mem_rw),
        .mem_a          (mem_a),
        .mem_wdata      (mem_wdata),
        .mem_rdata      (mem_rdata),
        .io_buffer_full (io_buffer_full),
        .tx_valid       (tx_valid),
        .tx_byte        (tx_byte),
        .tx_ready       (tx_ready),
        .rx_valid       (rx_valid),
        .rx_byte        (rx_byte),
        .sim_halt       (sim_halt),
        .err_flags      (err_flags)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One bus transaction; every transaction's rdata lands one cycle later.
    task automatic bus(input logic rw, input logic [31:0] a, input logic [7:0] d,
                       input logic [7:0] exp);
        exp_t e;
        mem_rw    = rw;
        mem_a     = a;
        mem_wdata = d;
        e.due     = cyc + 1;
        e.data    = exp;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        mem_rw    = 1'b0;
        mem_a     = 32'h0;
        mem_wdata = 8'h00;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst_in && exp_q.size() > 0 && exp_q[0].due <= cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            check("mem_rdata", {24'h0, mem_rdata}, {24'h0, e.data});
        end
    end

    always @(negedge clk) begin
        if (!rst_in && tx_valid && tx_ready) begin
            if (tx_q.size() == 0) check("tx_unexpected", 32'd1, 32'd0);
            else check("tx_byte", {24'h0, tx_byte}, {24'h0, tx_q.pop_front()});
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_in    = 1'b1;
        mem_rw    = 1'b0;
        mem_a     = 32'h0;
        mem_wdata = 8'h00;
        tx_ready  = 1'b0;
        rx_valid  = 1'b0;
        rx_byte   = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", {24'h0, mem_rdata}, 32'h0);
        check("rst_iofull", {31'h0, io_buffer_full}, 32'h0);
        check("rst_txvalid", {31'h0, tx_valid}, 32'h0);
        check("rst_halt", {31'h0, sim_halt}, 32'h0);
        check("rst_err", {30'h0, err_flags}, 32'h0);
        rst_in = 1'b0;

        // RAM, write-then-read and address wrap
        bus(1'b1, 32'h0001_0, 8'hA5, 8'h00);
        bus(1'b0, 32'h0001_0, 8'h00, 8'hA5);
        bus(1'b1, 32'h0002_0005, 8'h11, 8'h00);
        bus(1'b0, 32'h0000_0005, 8'h00, 8'h11);
        bus(1'b0, 32'h0002_0010, 8'h00, 8'hA5);
        bus(1'b0, 32'hFFFC_0010, 8'h00, 8'hA5);

        // Unmapped I/O and empty-FIFO reads
        bus(1'b1, 32'h0003_000C, 8'hEE, 8'h00);
        bus(1'b0, 32'h0003_0008, 8'h00, 8'h00);
        bus(1'b0, 32'h0003_0004, 8'h00, 8'h00);
        bus(1'b0, 32'h0003_0000, 8'h00, 8'h00);

        // RX path
        rx_pulse(8'h41);
        rx_pulse(8'h42);
        bus(1'b0, 32'h0003_0004, 8'h00, 8'h02);
        bus(1'b0, 32'h0003_0000, 8'h00, 8'h41);
        bus(1'b0, 32'h0003_0000, 8'h00, 8'h42);
        bus(1'b0, 32'h0003_0000, 8'h00, 8'h00);

        // RX overrun: nine pulses into eight entries
        for (int i = 0; i < 9; i++) rx_pulse(8'h60 + 8'(i));
        check("rx_overrun", {30'h0, err_flags}, 32'h2);
        bus(1'b0, 32'h0003_0004, 8'h00, 8'h02);
        for (int i = 0; i < 8; i++) bus(1'b0, 32'h0003_0000, 8'h00, 8'h60 + 8'(i));
        bus(1'b0, 32'h0003_0000, 8'h00, 8'h00);

        // TX fill to the near-full threshold and beyond
        for (int i = 0; i < 6; i++) begin
            bus(1'b1, 32'h0003_0000, 8'h10 + 8'(i), 8'h00);
            tx_q.push_back(8'h10 + 8'(i));
            if (i == 4) check("iofull_5", {31'h0, io_buffer_full}, 32'h0);
        end
        check("iofull_6", {31'h0, io_buffer_full}, 32'h1);
        for (int i = 6; i < 9; i++) begin
            bus(1'b1, 32'h0003_0000, 8'h10 + 8'(i), 8'h00);
            if (i < 8) tx_q.push_back(8'h10 + 8'(i));
        end
        check("tx_overflow", {30'h0, err_flags}, 32'h3);
        bus(1'b0, 32'h0003_0004, 8'h00, 8'h01);

        // Drain; near-full drops when the count falls to five
        tx_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            #1;
            check("iofull_drain", {31'h0, io_buffer_full}, {31'h0, (8 - k) >= 6});
        end
        check("tx_drained", {31'h0, tx_valid}, 32'h0);
        check("tx_q_empty", tx_q.size(), 32'h0);
        tx_ready = 1'b0;

        // Halt request
        check("halt_before", {31'h0, sim_halt}, 32'h0);
        bus(1'b1, 32'h0003_0004, 8'h01, 8'h00);
        check("halt_after", {31'h0, sim_halt}, 32'h1);

        // Reset mid-drain with three bytes still queued
        for (int i = 0; i < 4; i++) begin
            bus(1'b1, 32'h0003_0000, 8'hC0 + 8'(i), 8'h00);
            tx_q.push_back(8'hC0 + 8'(i));
        end
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        rst_in    = 1'b1;
        mem_rw    = 1'b1;
        mem_a     = 32'h0001_0;
        mem_wdata = 8'h5A;
        #1;
        tx_q.delete();
        exp_q.delete();
        check("rst_mid_txvalid", {31'h0, tx_valid}, 32'h0);
        check("rst_mid_halt", {31'h0, sim_halt}, 32'h0);
        check("rst_mid_err", {30'h0, err_flags}, 32'h0);
        check("rst_mid_iofull", {31'h0, io_buffer_full}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_mid_rdata", {24'h0, mem_rdata}, 32'h0);
        rst_in    = 1'b0;
        tx_ready  = 1'b0;
        mem_rw    = 1'b0;
        mem_a     = 32'h0;
        mem_wdata = 8'h00;
        bus(1'b0, 32'h0001_0, 8'h00, 8'hA5);
        bus(1'b0, 32'h0000_0005, 8'h00, 8'h11);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_empty", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
